// File: rtl/memory_access_stage.sv
// RV64 memory access stage: one outstanding req/ack access, lane placement,
// load extension, misalignment trap and registered writeback outputs.
module memory_access_stage (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  width_signal_in,
  input  logic        rd_write_signal_in,
  input  logic        read_signal_in,
  input  logic        write_signal_in,
  input  logic        wb_src_signal_in,
  input  logic        valid_instr_signal_in,
  input  logic        flush_signal_in,
  input  logic [63:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [63:0] mem_addr_out,
  output logic [63:0] mem_wdata_out,
  output logic [7:0]  mem_wstrb_out,
  output logic        stall_signal_out,
  output logic [63:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_signal_out,
  output logic        valid_instr_signal_out,
  output logic        misaligned_signal_out,
  output logic [63:0] bad_addr_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state;
  logic [63:0] lat_addr;
  logic [2:0]  lat_width;
  logic [4:0]  lat_rd;
  logic        lat_rd_write;
  logic        lat_wb_src;
  logic        lat_valid;

  logic        mem_op;
  logic        misaligned;
  logic [63:0] st_wdata;
  logic [7:0]  st_wstrb;
  logic [63:0] shifted;
  logic [63:0] load_data;
  logic [63:0] wb_value;

  assign mem_op = (read_signal_in | write_signal_in)
                & ~flush_signal_in;
  assign mem_req_out = (state == BUSY);

  always_comb begin
    misaligned = 1'b0;
    st_wdata   = rs2_value_in;
    st_wstrb   = 8'hFF;
    unique case (1'b1)
      (width_signal_in[1:0] == 2'b00): begin
        st_wdata = {8{rs2_value_in[7:0]}};
        st_wstrb = 8'h01 << alu_result_in[2:0];
      end
      (width_signal_in[1:0] == 2'b01): begin
        misaligned = alu_result_in[0];
        st_wdata   = {4{rs2_value_in[15:0]}};
        st_wstrb   = 8'h03 << alu_result_in[2:0];
      end
      (width_signal_in[1:0] == 2'b10): begin
        misaligned = |alu_result_in[1:0];
        st_wdata   = {2{rs2_value_in[31:0]}};
        st_wstrb   = 8'h0F << alu_result_in[2:0];
      end
      (width_signal_in[1:0] == 2'b11): begin
        misaligned = |alu_result_in[2:0];
      end
    endcase
  end

  always_comb begin
    shifted   = mem_rdata_in >> {lat_addr[2:0], 3'b000};
    load_data = shifted;
    unique case (1'b1)
      (lat_width[1:0] == 2'b00):
        load_data = {{56{shifted[7] & ~lat_width[2]}},
                     shifted[7:0]};
      (lat_width[1:0] == 2'b01):
        load_data = {{48{shifted[15] & ~lat_width[2]}},
                     shifted[15:0]};
      (lat_width[1:0] == 2'b10):
        load_data = {{32{shifted[31] & ~lat_width[2]}},
                     shifted[31:0]};
      (lat_width[1:0] == 2'b11):
        load_data = shifted;
    endcase
    wb_value = lat_wb_src ? load_data : lat_addr;
  end

  always_comb begin
    stall_signal_out = 1'b0;
    if (state == BUSY)
      stall_signal_out = ~mem_ack_in;
    else
      stall_signal_out = mem_op & ~misaligned;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                  <= IDLE;
      lat_addr               <= '0;
      lat_width              <= '0;
      lat_rd                 <= '0;
      lat_rd_write           <= 1'b0;
      lat_wb_src             <= 1'b0;
      lat_valid              <= 1'b0;
      mem_we_out             <= 1'b0;
      mem_addr_out           <= '0;
      mem_wdata_out          <= '0;
      mem_wstrb_out          <= '0;
      wb_data_out            <= '0;
      rd_out                 <= '0;
      rd_write_signal_out    <= 1'b0;
      valid_instr_signal_out <= 1'b0;
      misaligned_signal_out  <= 1'b0;
      bad_addr_out           <= '0;
    end else if (state == IDLE) begin
      misaligned_signal_out <= 1'b0;
      rd_out                <= rd_in;
      wb_data_out           <= alu_result_in;
      if (mem_op && !misaligned) begin
        state                  <= BUSY;
        lat_addr               <= alu_result_in;
        lat_width              <= width_signal_in;
        lat_rd                 <= rd_in;
        lat_rd_write           <= rd_write_signal_in
                                & ~write_signal_in;
        lat_wb_src             <= wb_src_signal_in;
        lat_valid              <= valid_instr_signal_in
                                | write_signal_in;
        mem_we_out             <= write_signal_in;
        mem_addr_out           <= {alu_result_in[63:3], 3'b000};
        mem_wdata_out          <= st_wdata;
        mem_wstrb_out          <= write_signal_in ? st_wstrb : 8'h00;
        rd_write_signal_out    <= 1'b0;
        valid_instr_signal_out <= 1'b0;
      end else if (mem_op) begin
        misaligned_signal_out  <= 1'b1;
        bad_addr_out           <= alu_result_in;
        rd_write_signal_out    <= 1'b0;
        valid_instr_signal_out <= 1'b0;
      end else begin
        rd_write_signal_out    <= rd_write_signal_in
                                & ~flush_signal_in;
        valid_instr_signal_out <= valid_instr_signal_in
                                & ~flush_signal_in;
      end
    end else if (mem_ack_in) begin
      state                  <= IDLE;
      wb_data_out            <= wb_value;
      rd_out                 <= lat_rd;
      rd_write_signal_out    <= lat_rd_write;
      valid_instr_signal_out <= lat_valid;
    end
  end

endmodule
